// File: rtl/hvac_pkg.sv
`default_nettype none
// ============================================================================
// hvac_pkg
// Shared state encodings and widths for the HVAC sequencer.
// Rev 1.0 - initial release
// ============================================================================
package hvac_pkg;

  localparam int STATE_W = 3;
  localparam int DWELL_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'b000,
    S_HEAT_LEAD = 3'b001,
    S_HEAT_ON   = 3'b010,
    S_COOL_LEAD = 3'b011,
    S_COOL_ON   = 3'b100,
    S_LAG       = 3'b101,
    S_LOCKOUT   = 3'b110
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hvac_demand.sv
`default_nettype none
// ============================================================================
// hvac_demand
// Combinational demand/satisfaction decode from latched setpoint and sample.
// Rev 1.0 - initial release
// ============================================================================
module hvac_demand #(
  parameter int ON_BAND  = 4,
  parameter int OFF_BAND = 0
) (
  input  logic [7:0] i_set_q,
  input  logic [7:0] i_act_q,
  output logic       o_need_heat,
  output logic       o_need_cool,
  output logic       o_heat_sat,
  output logic       o_cool_sat
);

  localparam logic signed [8:0] c_on_band  = 9'(ON_BAND);
  localparam logic signed [8:0] c_off_band = 9'(OFF_BAND);

  logic signed [8:0] w_diff;
  logic signed [8:0] w_ndiff;

  // Zero-extend before subtracting so large opposite readings never wrap
  assign w_diff  = $signed({1'b0, i_set_q}) - $signed({1'b0, i_act_q});
  assign w_ndiff = -w_diff;

  assign o_need_heat = (w_diff  >= c_on_band);
  assign o_need_cool = (w_ndiff >= c_on_band);
  assign o_heat_sat  = (w_ndiff >= c_off_band);
  assign o_cool_sat  = (w_diff  >= c_off_band);

endmodule
`default_nettype wire

// File: rtl/hvac_sequencer.sv
`default_nettype none
// ============================================================================
// hvac_sequencer
// Moore sequencer for heater, cooler and fan with lead/lag, min-on and lockout.
// Rev 1.0 - initial release
// ============================================================================
module hvac_sequencer
  import hvac_pkg::*;
#(
  parameter int ON_BAND  = 4,
  parameter int OFF_BAND = 0,
  parameter int FAN_LEAD = 2,
  parameter int FAN_LAG  = 3,
  parameter int MIN_ON   = 8,
  parameter int MIN_OFF  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         Tset,
  input  logic [7:0]         Tact,
  input  logic               sample_valid,
  output logic               heat_en,
  output logic               cool_en,
  output logic               fan_en,
  output logic [STATE_W-1:0] state
);

  localparam logic [DWELL_W-1:0] c_lead_last   = DWELL_W'(FAN_LEAD - 1);
  localparam logic [DWELL_W-1:0] c_lag_last    = DWELL_W'(FAN_LAG - 1);
  localparam logic [DWELL_W-1:0] c_min_on_last = DWELL_W'(MIN_ON - 1);
  localparam logic [DWELL_W-1:0] c_min_off_last= DWELL_W'(MIN_OFF - 1);

  logic [7:0]         r_set_q;
  logic [7:0]         r_act_q;
  state_e             r_state;
  state_e             w_next;
  logic [DWELL_W-1:0] r_dwell;
  logic               w_need_heat;
  logic               w_need_cool;
  logic               w_heat_sat;
  logic               w_cool_sat;

  hvac_demand #(
    .ON_BAND  (ON_BAND),
    .OFF_BAND (OFF_BAND)
  ) u_demand (
    .i_set_q     (r_set_q),
    .i_act_q     (r_act_q),
    .o_need_heat (w_need_heat),
    .o_need_cool (w_need_cool),
    .o_heat_sat  (w_heat_sat),
    .o_cool_sat  (w_cool_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_set_q <= '0;
      r_act_q <= '0;
      r_state <= S_IDLE;
      r_dwell <= '0;
    end else begin
      if (sample_valid) begin
        r_set_q <= Tset;
        r_act_q <= Tact;
      end
      r_state <= w_next;
      if (w_next != r_state)
        r_dwell <= '0;
      else if (r_dwell != {DWELL_W{1'b1}})
        r_dwell <= r_dwell + 1'b1;
    end
  end

  always_comb begin
    w_next  = r_state;
    heat_en = 1'b0;
    cool_en = 1'b0;
    fan_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_need_heat)      w_next = S_HEAT_LEAD;
        else if (w_need_cool) w_next = S_COOL_LEAD;
      end
      S_HEAT_LEAD: begin
        fan_en = 1'b1;
        if (!w_need_heat)                w_next = S_LAG;
        else if (r_dwell == c_lead_last) w_next = S_HEAT_ON;
      end
      S_HEAT_ON: begin
        fan_en  = 1'b1;
        heat_en = 1'b1;
        if (r_dwell >= c_min_on_last && w_heat_sat) w_next = S_LAG;
      end
      S_COOL_LEAD: begin
        fan_en = 1'b1;
        if (!w_need_cool)                w_next = S_LAG;
        else if (r_dwell == c_lead_last) w_next = S_COOL_ON;
      end
      S_COOL_ON: begin
        fan_en  = 1'b1;
        cool_en = 1'b1;
        if (r_dwell >= c_min_on_last && w_cool_sat) w_next = S_LAG;
      end
      S_LAG: begin
        fan_en = 1'b1;
        if (r_dwell == c_lag_last) w_next = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        if (r_dwell == c_min_off_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire
